// File: rtl/mem_access_ctrl.sv
// Request-stream to pin-level sequencer for a 2048x16 single-port memory.
// One request in flight; owns data-bus turnaround between controller and memory.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic                  mem_output_enable,
    output logic                  mem_reset,
    inout  wire  [DATA_WIDTH-1:0] mem_data_bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_OE,
        WR,
        CLR,
        RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  bus_drive;

    // Drive enable is a register set only for the WR cycle, so it can never
    // overlap mem_output_enable, which is set only for the RD_OE cycle.
    assign mem_data_bus = bus_drive ? wdata_q : {DATA_WIDTH{1'bz}};

    // NOTE: every output is assigned for the state being entered, so each one
    // comes straight from a flop and the async reset clears it immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            wdata_q           <= '0;
            bus_drive         <= 1'b0;
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_err          <= 1'b0;
            resp_rdata        <= '0;
            mem_address       <= '0;
            mem_write_enable  <= 1'b0;
            mem_output_enable <= 1'b0;
            mem_reset         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wdata_q   <= req_wdata;
                        case (req_op)
                            OP_READ: begin
                                state       <= RD_ADDR;
                                mem_address <= req_addr;
                            end
                            OP_WRITE: begin
                                state            <= WR;
                                mem_address      <= req_addr;
                                mem_write_enable <= 1'b1;
                                bus_drive        <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state     <= CLR;
                                mem_reset <= 1'b1;
                            end
                            default: begin
                                state      <= RESP;
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_ADDR: begin
                    // Memory has loaded its output register on this edge.
                    state             <= RD_OE;
                    mem_output_enable <= 1'b1;
                end
                RD_OE: begin
                    state             <= RESP;
                    mem_output_enable <= 1'b0;
                    resp_rdata        <= mem_data_bus;
                    resp_valid        <= 1'b1;
                end
                WR: begin
                    state            <= RESP;
                    mem_write_enable <= 1'b0;
                    bus_drive        <= 1'b0;
                    resp_valid       <= 1'b1;
                end
                CLR: begin
                    state      <= RESP;
                    mem_reset  <= 1'b0;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural memory on the pins,
// array scoreboard of expected contents, directed cases then random traffic.
module tb_mem_access_ctrl;

    localparam int AW = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic          mem_output_enable;
    logic          mem_reset;
    wire  [DW-1:0] mem_data_bus;

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_rdata        (resp_rdata),
        .resp_err          (resp_err),
        .mem_address       (mem_address),
        .mem_write_enable  (mem_write_enable),
        .mem_output_enable (mem_output_enable),
        .mem_reset         (mem_reset),
        .mem_data_bus      (mem_data_bus)
    );

    always #5 clk = ~clk;

    // Pin-level memory: sync write, sync clear, registered output gated by oe.
    logic [DW-1:0] mem_arr [0:2047];
    logic [DW-1:0] mem_q;
    assign mem_data_bus = mem_output_enable ? mem_q : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_reset) begin
            for (int i = 0; i < 2048; i++) mem_arr[i] <= '0;
            mem_q <= '0;
        end else begin
            if (mem_write_enable) mem_arr[mem_address] <= mem_data_bus;
            mem_q <= mem_arr[mem_address];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pin activity monitor, sampled on the falling edge.
    bit            mon_en = 1'b0;
    int            we_cnt, oe_cnt, rst_cnt;
    logic [DW-1:0] wr_bus;

    always @(negedge clk) begin
        if (mon_en) begin
            check("we_oe_overlap", {31'd0, mem_write_enable && mem_output_enable}, 32'd0);
            if (mem_write_enable) begin
                we_cnt++;
                wr_bus = mem_data_bus;
            end
            if (mem_output_enable) begin
                oe_cnt++;
                check("oe_bus_clean", {16'd0, mem_data_bus}, {16'd0, mem_q});
            end
            if (mem_reset) rst_cnt++;
        end
    end

    // Scoreboard: expected memory contents and the last returned read data.
    logic [DW-1:0] ref_mem [0:2047];
    logic [DW-1:0] last_rd;

    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input int hold);
        int            lat;
        int            waited;
        int            exp_lat;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        exp_err = (op == 2'b11);
        case (op)
            2'b00:   begin exp_lat = 3; exp_rd = ref_mem[addr]; end
            2'b01:   begin exp_lat = 2; exp_rd = last_rd; ref_mem[addr] = wd; end
            2'b10:   begin exp_lat = 2; exp_rd = last_rd;
                           for (int i = 0; i < 2048; i++) ref_mem[i] = '0; end
            default: begin exp_lat = 1; exp_rd = last_rd; end
        endcase
        last_rd = exp_rd;

        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        we_cnt = 0; oe_cnt = 0; rst_cnt = 0;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        check("resp_latency", lat, exp_lat);
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        check("resp_rdata", {16'd0, resp_rdata}, {16'd0, exp_rd});
        check("we_pulses", we_cnt, (op == 2'b01) ? 1 : 0);
        check("oe_pulses", oe_cnt, (op == 2'b00) ? 1 : 0);
        check("clr_pulses", rst_cnt, (op == 2'b10) ? 1 : 0);
        if (op == 2'b01) check("wr_bus_data", {16'd0, wr_bus}, {16'd0, wd});

        for (int h = 0; h < hold; h++) begin
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_err", {31'd0, resp_err}, {31'd0, exp_err});
            check("hold_rdata", {16'd0, resp_rdata}, {16'd0, exp_rd});
            check("hold_no_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("post_valid", {31'd0, resp_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        last_rd    = '0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_ctrl", {29'd0, mem_write_enable, mem_output_enable, mem_reset}, 32'd0);
        check("rst_mem_addr", {21'd0, mem_address}, 32'd0);
        mon_en = 1'b1;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_req_ready", {31'd0, req_ready}, 32'd1);
        check("rel_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rel_resp_rdata", {16'd0, resp_rdata}, 32'd0);

        do_req(2'b01, 11'h005, 16'hBEEF, 0);
        do_req(2'b00, 11'h005, 16'h0000, 0);
        do_req(2'b01, 11'h7FF, 16'h1234, 0);
        do_req(2'b01, 11'h000, 16'hABCD, 0);
        do_req(2'b00, 11'h7FF, 16'h0000, 0);
        do_req(2'b00, 11'h000, 16'h0000, 0);
        do_req(2'b01, 11'h010, 16'h5555, 0);
        do_req(2'b10, 11'h000, 16'h0000, 0);
        do_req(2'b00, 11'h010, 16'h0000, 0);

        // Reset asserted in the middle of a WR cycle drops the write.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 11'h3A0; req_wdata = 16'hDEAD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("midwr_we", {31'd0, mem_write_enable}, 32'd1);
        check("midwr_bus", {16'd0, mem_data_bus}, 32'h0000DEAD);
        #2 reset = 1'b0;
        #1;
        check("midrst_we", {31'd0, mem_write_enable}, 32'd0);
        check("midrst_oe", {31'd0, mem_output_enable}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        last_rd = '0;
        repeat (2) @(negedge clk);
        check("midrel_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrel_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrel_rdata", {16'd0, resp_rdata}, 32'd0);
        do_req(2'b00, 11'h3A0, 16'h0000, 0);

        do_req(2'b11, 11'h123, 16'h0000, 5);

        for (int n = 0; n < 60; n++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(9, 0));
            op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            do_req(op, AW'($urandom), DW'($urandom), int'($urandom_range(2, 0)));
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
